fetch_sequencer: RTL

Sequences the byte-addressed, little-endian instruction memory: boot-loads program words into it one byte per cycle, then fetches. During fetch it drives PC, registers the returned 32-bit instruction, and handles stall, branch redirect and halt. It sits between the program loader/testbench, the instruction memory (combinational read, byte write port) and the decode stage.

---
 rtl/fetch_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Boot-loads program words byte-by-byte into instruction memory,
//            then fetches with stall, branch redirect and halt handling.
// Options  : FETCH_PERF_CNT_EN - saturating issued-instruction counter
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int unsigned MEM_BYTES = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  input  logic        load_done,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [7:0]  mem_wdata,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] c_addr_mask = 32'(MEM_BYTES - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_WRITE = 2'd1,
    S_RUN   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_ptr;
  logic [31:0] r_word;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic        r_halted;

  logic        w_issue;
  logic [7:0]  w_byte;
  logic [31:0] w_redirect_target;

  assign w_issue           = (r_state == S_RUN) && !redirect_valid && !stall;
  assign w_redirect_target = (redirect_pc & ~32'd3) & c_addr_mask;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a simultaneous load_valid wins over load_done
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD: begin
        if (load_valid) begin
          w_state_next = S_WRITE;
        end else if (load_done) begin
          w_state_next = S_RUN;
        end
      end
      S_WRITE: begin
        if (r_byte_idx == 2'd3) begin
          w_state_next = S_LOAD;
        end
      end
      S_RUN: begin
        if (w_issue && (instr_in == HALT_WORD)) begin
          w_state_next = S_HALT;
        end
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_LOAD;
      end
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_byte_idx)
      2'd0:    w_byte = r_word[7:0];
      2'd1:    w_byte = r_word[15:8];
      2'd2:    w_byte = r_word[23:16];
      default: w_byte = r_word[31:24];
    endcase
  end

  // Write port is quiet (all zero) outside the byte-write phase
  always_comb begin
    load_ready = (r_state == S_LOAD);
    mem_we     = (r_state == S_WRITE);
    mem_waddr  = 32'd0;
    mem_wdata  = 8'h00;
    if (r_state == S_WRITE) begin
      mem_waddr = r_ptr + {30'd0, r_byte_idx};
      mem_wdata = w_byte;
    end
  end

  // Loader and fetch datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr         <= 32'd0;
      r_word        <= 32'd0;
      r_byte_idx    <= 2'd0;
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_instr_pc    <= 32'd0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_byte_idx <= 2'd0;
          if (load_valid) begin
            r_word <= load_data;
          end else if (load_done) begin
            r_pc <= RESET_PC & c_addr_mask;
          end
        end
        S_WRITE: begin
          r_byte_idx <= r_byte_idx + 2'd1;
          if (r_byte_idx == 2'd3) begin
            r_ptr <= (r_ptr + 32'd4) & c_addr_mask;
          end
        end
        S_RUN: begin
          if (redirect_valid) begin
            r_pc          <= w_redirect_target;
            r_instr_valid <= 1'b0;
          end else if (!stall) begin
            r_instr       <= instr_in;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_pc          <= (r_pc + 32'd4) & c_addr_mask;
          end
        end
        S_HALT: begin
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b1;
        end
        default: begin
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pc_out      = r_pc;
  assign instr_out   = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= 32'd0;
    end else if (w_issue && (r_fetch_count != 32'hFFFF_FFFF)) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`else
  assign fetch_count = 32'd0;
`endif

endmodule
`default_nettype wire
